// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event buffer.
// Optional autorepeat filtering is controlled by KBD_TYPEMATIC_FILTER_EN (see kbd_buf_ctrl).
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Bit positions inside the key_data word seen by the CPU.
  localparam int KD_VALID   = 31;
  localparam int KD_OVF     = 30;
  localparam int KD_CNT_LSB = 16;
  localparam int KD_EXT     = 9;
  localparam int KD_BRK     = 8;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_entry_t;

  localparam int ENTRY_W = $bits(kbd_entry_t);

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Generic synchronous show-ahead FIFO: head always shows the oldest entry.
// A pop while empty is ignored; a push while full is accepted only alongside a pop.
module kbd_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  do_push, do_pop;

  always_comb begin
    full    = (count_q == CNT_FULL);
    empty   = (count_q == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/kbd_buf_ctrl.sv
// PS/2 scancode parser + event FIFO behind the CPU keyboard window (0x003xxxxx).
// Define KBD_TYPEMATIC_FILTER_EN to drop autorepeated make events.
module kbd_buf_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        read_key,
  output logic [31:0] key_data,
  output logic        key_pending,
  output logic [1:0]  dbg_state
);

  kbd_state_e state_q, state_d;
  logic       read_key_q;
  logic       ovf_q, ovf_d;

  kbd_entry_t          ev;
  logic                ev_valid;
  logic                push_req;
  logic                pop_edge;
  logic                drop;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  kbd_entry_t          head;

  // Parser: prefixes only move state; any other byte terminates the event.
  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev.ext   = (state_q == EXT) || (state_q == EXTBRK);
    ev.brk   = (state_q == BRK) || (state_q == EXTBRK);
    ev.code  = byte_in;
    if (byte_valid) begin
      unique case (state_q)
        IDLE: begin
          if (byte_in == PS2_EXT)      state_d = EXT;
          else if (byte_in == PS2_BRK) state_d = BRK;
          else                         ev_valid = 1'b1;
        end
        EXT: begin
          if (byte_in == PS2_BRK)      state_d = EXTBRK;
          else if (byte_in != PS2_EXT) begin
            ev_valid = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          if (!is_prefix(byte_in)) begin
            ev_valid = 1'b1;
            state_d  = IDLE;
          end
        end
      endcase
    end
  end

  assign pop_edge = read_key & ~read_key_q;

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       lm_valid_q, lm_valid_d;
  logic       lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       lm_match;

  always_comb begin
    lm_match   = lm_valid_q && (lm_ext_q == ev.ext) && (lm_code_q == ev.code);
    push_req   = ev_valid & ~(~ev.brk & lm_match);
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    // Only a make that actually lands in the FIFO becomes the repeat reference.
    if (push_req && !ev.brk && (!fifo_full || pop_edge)) begin
      lm_valid_d = 1'b1;
      lm_ext_d   = ev.ext;
      lm_code_d  = ev.code;
    end else if (ev_valid && ev.brk && lm_match) begin
      lm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= 8'h00;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end
`else
  assign push_req = ev_valid;
`endif

  // A drop outranks the clearing pop edge, keeping overflow set.
  always_comb begin
    drop  = push_req & fifo_full & ~pop_edge;
    ovf_d = ovf_q;
    if (drop)          ovf_d = 1'b1;
    else if (pop_edge) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      read_key_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_key_q <= read_key;
      ovf_q      <= ovf_d;
    end
  end

  kbd_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push_req),
    .pop   (pop_edge),
    .din   (ev),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  always_comb begin
    key_data                       = '0;
    key_data[KD_VALID]             = ~fifo_empty;
    key_data[KD_OVF]               = ovf_q;
    key_data[KD_CNT_LSB +: 8]      = 8'(fifo_count);
    if (!fifo_empty) begin
      key_data[KD_EXT]             = head.ext;
      key_data[KD_BRK]             = head.brk;
      key_data[7:0]                = head.code;
    end
  end

  assign key_pending = ~fifo_empty;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_kbd_buf_ctrl.sv
// Self-checking bench for kbd_buf_ctrl: vector table + hand sequences, scoreboard queue.
module tb_kbd_buf_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        read_key;
  logic [31:0] key_data;
  logic        key_pending;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [39:0] bytes;  // first byte in bits [7:0]
    int          n;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs [7];

  kbd_buf_ctrl #(.DEPTH_LOG2(3)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .read_key    (read_key),
    .key_data    (key_data),
    .key_pending (key_pending),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] kd_word(input logic ovf, input int cnt, input logic [9:0] e);
    return {1'b1, ovf, 6'b0, 8'(cnt), 6'b0, e};
  endfunction

  // driver tasks
  task automatic reset_dut();
    @(negedge clk);
    clrn = 1'b0;
    #3;
    clrn = 1'b1;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_read(input int n);
    @(negedge clk);
    read_key = 1'b1;
    repeat (n) @(negedge clk);
    read_key = 1'b0;
  endtask

  // scoreboard: compare the head against the queue front, one pop per access
  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      check(name, key_data, kd_word(1'b0, exp_q.size(), exp_q[0]));
      do_read($urandom_range(1, 4));
      void'(exp_q.pop_front());
    end
    check({name, "_empty"}, key_data, 32'h0);
    check({name, "_pending"}, 32'(key_pending), 32'h0);
  endtask

  initial begin
    vecs[0] = '{bytes: 40'h000000001C, n: 1, exp: 10'h01C};
    vecs[1] = '{bytes: 40'h00000075E0, n: 2, exp: 10'h275};
    vecs[2] = '{bytes: 40'h0000001CF0, n: 2, exp: 10'h11C};
    vecs[3] = '{bytes: 40'h000075F0E0, n: 3, exp: 10'h375};
    vecs[4] = '{bytes: 40'h000011E0E0, n: 3, exp: 10'h211};
    vecs[5] = '{bytes: 40'h002AF0E0F0, n: 4, exp: 10'h12A};
    vecs[6] = '{bytes: 40'h74F0E0F0E0, n: 5, exp: 10'h374};

    clrn = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; read_key = 1'b0;
    #22 clrn = 1'b1;
    @(negedge clk);
    check("reset_key_data", key_data, 32'h0);
    check("reset_pending", 32'(key_pending), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);

    // single make, held read pops exactly once
    send_byte(8'h1C);
    check("make_1c", key_data, 32'h8001_001C);
    check("make_1c_pending", 32'(key_pending), 32'h1);
    do_read(3);
    check("make_1c_popped", key_data, 32'h0);
    send_byte(8'h1C);
    send_byte(8'h1D);
    do_read(3);
    check("one_pop_per_access", key_data, 32'h8001_001D);
    do_read(1);
    check("two_pop_empty", key_data, 32'h0);

    // table-driven parser vectors
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].bytes[8*j +: 8]);
      exp_q.push_back(vecs[i].exp);
    end
    drain("table");

    // overflow: 9 makes with no reads
    reset_dut();
    for (int c = 8'h10; c <= 8'h18; c++) begin
      send_byte(8'(c));
      if (exp_q.size() < 8) exp_q.push_back(10'(c));
    end
    check("ovf_word", key_data, 32'hC008_0010);
    check("ovf_pending", 32'(key_pending), 32'h1);
    do_read(1);
    void'(exp_q.pop_front());
    check("ovf_first_pop", key_data, 32'h8007_0011);
    drain("ovf_drain");

    // full FIFO: push and pop edge in the same cycle
    reset_dut();
    for (int c = 8'h10; c <= 8'h17; c++) begin
      send_byte(8'(c));
      exp_q.push_back(10'(c));
    end
    check("full_word", key_data, kd_word(1'b0, 8, 10'h010));
    @(negedge clk);
    byte_valid = 1'b1; byte_in = 8'h20; read_key = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; read_key = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(10'h020);
    check("full_push_pop", key_data, 32'h8008_0011);
    drain("full_drain");

    // pop while empty, then push+pop while empty
    do_read(2);
    check("empty_pop", key_data, 32'h0);
    @(negedge clk);
    byte_valid = 1'b1; byte_in = 8'h2B; read_key = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; read_key = 1'b0;
    exp_q.push_back(10'h02B);
    check("empty_push_pop", key_data, 32'h8001_002B);
    drain("empty_drain");

    // asynchronous reset in the middle of a prefix
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("prefix_state", 32'(dbg_state), 32'h3);
    reset_dut();
    check("midreset_data", key_data, 32'h0);
    check("midreset_state", 32'(dbg_state), 32'h0);
    send_byte(8'h1C);
    check("after_midreset", key_data, 32'h8001_001C);
    exp_q.push_back(10'h01C);
    drain("midreset_drain");

    // typematic repeats
    reset_dut();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h11C);
    exp_q.push_back(10'h01C);
`else
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h11C);
    exp_q.push_back(10'h01C);
`endif
    drain("typematic");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
